// File: rtl/flip_flop_shift_reg_pkg.sv
// Shared constants for the flip-flop-chain shift register.
package flip_flop_shift_reg_pkg;

  // Stage count used when the instantiating code does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Smallest chain that still has distinct newest and oldest stages.
  localparam int MIN_WIDTH = 2;

endpackage : flip_flop_shift_reg_pkg

// File: rtl/flip_flop_shift_reg_if.sv
// Data bundle of the shift register: serial input, parallel and serial outputs.
// The master drives sin and observes the register; the slave is the register.
interface flip_flop_shift_reg_if
  import flip_flop_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             sin;  // serial data entering the MSB stage
  logic [WIDTH-1:0] out;  // out[WIDTH-1] newest bit, out[0] oldest bit
  logic             so;   // serial data out, same as out[0]

  modport master (
    output sin,
    input  out,
    input  so
  );

  modport slave (
    input  sin,
    output out,
    output so
  );

endinterface : flip_flop_shift_reg_if

// File: rtl/flip_flop_shift_reg_dff_sync_rst_n.sv
// Single D flip-flop with synchronous active-low clear; one stage of the chain.
module dff_sync_rst_n (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Capture d on every rising edge, or clear when rst is sampled low.
  // NOTE: clocked state uses non-blocking assignment so that every stage
  // samples its neighbour's pre-edge value and the chain shifts by exactly
  // one position per edge, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

endmodule : dff_sync_rst_n

// File: rtl/flip_flop_shift_reg.sv
// Serial-in, parallel-out / serial-out shift register built structurally as a
// chain of WIDTH discrete D flip-flops. sin enters the MSB stage, the contents
// move one stage towards bit 0 per clock, and bit 0 is the serial output.
// WIDTH must be at least MIN_WIDTH and must match the width of the bus.
module flip_flop_shift_reg
  import flip_flop_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,  // synchronous, active low
  flip_flop_shift_reg_if.slave bus
);

  // s[WIDTH] is the chain input, s[i] is the output of stage i.
  logic [WIDTH:0] s;

  // Feed the serial input into the head of the chain.
  assign s[WIDTH] = bus.sin;

  // One flip-flop per bit, each fed by the stage above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    dff_sync_rst_n u_dff (
      .clk (clk),
      .rst (rst),
      .d   (s[i+1]),
      .q   (s[i])
    );
  end : g_stage

  // Parallel view of all stages; the serial output is a wire copy of stage 0,
  // so there is no extra register delay on so.
  assign bus.out = s[WIDTH-1:0];
  assign bus.so  = s[0];

endmodule : flip_flop_shift_reg

// File: tb/tb_flip_flop_shift_reg.sv
// Self-checking bench for flip_flop_shift_reg: directed vector table, a
// hand-written mid-shift reset sequence, and a random stream compared against
// a queue-based history model.
module tb_flip_flop_shift_reg;

  localparam int W = 8;

  typedef struct {
    logic         rst;
    logic         sin;
    logic [W-1:0] exp_out;
    logic         exp_so;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int errors = 0;
  int checks = 0;

  flip_flop_shift_reg_if #(.WIDTH(W)) bus ();

  flip_flop_shift_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive inputs away from the active edge, then let one rising edge pass and
  // return shortly after it so outputs can be sampled.
  task automatic step(input logic rst_v, input logic sin_v);
    @(negedge clk);
    rst     = rst_v;
    bus.sin = sin_v;
    @(posedge clk);
    #1;
  endtask

  // Reference: the register holds the last W bits shifted in since the most
  // recent reset, newest at the MSB, with zeros where nothing has arrived yet.
  bit hist[$];

  task automatic model_edge(input logic rst_v, input logic sin_v);
    if (!rst_v) hist.delete();
    else begin
      hist.push_back(sin_v);
      if (hist.size() > W) void'(hist.pop_front());
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] r = '0;
    int n = hist.size();
    for (int k = 0; k < n; k++) r[W - n + k] = hist[k];
    return r;
  endfunction

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s,
                              input logic [W-1:0] o, input logic so_v);
    vec_t v;
    v.rst = r; v.sin = s; v.exp_out = o; v.exp_so = so_v;
    vecs.push_back(v);
  endfunction

  initial begin
    bus.sin = 1'b0;

    // Reset with sin high: clears regardless of sin.
    add(0, 1, 8'h00, 0);
    add(0, 1, 8'h00, 0);
    // Fill with ones.
    add(1, 1, 8'h80, 0);
    add(1, 1, 8'hC0, 0);
    add(1, 1, 8'hE0, 0);
    add(1, 1, 8'hF0, 0);
    add(1, 1, 8'hF8, 0);
    add(1, 1, 8'hFC, 0);
    add(1, 1, 8'hFE, 0);
    add(1, 1, 8'hFF, 1);
    // Drain with zeros.
    add(1, 0, 8'h7F, 1);
    add(1, 0, 8'h3F, 1);
    add(1, 0, 8'h1F, 1);
    add(1, 0, 8'h0F, 1);
    // Reset, then pattern 1,0,1,1,0,0,1,0.
    add(0, 0, 8'h00, 0);
    add(1, 1, 8'h80, 0);
    add(1, 0, 8'h40, 0);
    add(1, 1, 8'hA0, 0);
    add(1, 1, 8'hD0, 0);
    add(1, 0, 8'h68, 0);
    add(1, 0, 8'h34, 0);
    add(1, 1, 8'h9A, 0);
    add(1, 0, 8'h4D, 1);
    add(1, 0, 8'h26, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].sin);
      check($sformatf("vec%0d out", i), bus.out, vecs[i].exp_out);
      check($sformatf("vec%0d so", i), W'(bus.so), W'(vecs[i].exp_so));
    end

    // Mid-shift reset: fill to FF, reset for two edges with sin high, release.
    step(0, 0);
    for (int i = 0; i < W; i++) step(1, 1);
    check("mid pre-reset out", bus.out, 8'hFF);
    step(0, 1);
    check("mid reset edge1 out", bus.out, 8'h00);
    check("mid reset edge1 so", W'(bus.so), W'(1'b0));
    step(0, 1);
    check("mid reset edge2 out", bus.out, 8'h00);
    step(1, 1);
    check("mid release out", bus.out, 8'h80);
    check("mid release so", W'(bus.so), W'(1'b0));

    // Random stream against the history model; start from a known reset.
    step(0, 0);
    model_edge(0, 0);
    for (int c = 0; c < 200; c++) begin
      logic r_v, s_v;
      logic [W-1:0] exp_o;
      r_v = ($urandom_range(0, 15) != 0);
      s_v = 1'($urandom);
      step(r_v, s_v);
      model_edge(r_v, s_v);
      exp_o = model_out();
      check($sformatf("rand%0d out", c), bus.out, exp_o);
      check($sformatf("rand%0d so", c), W'(bus.so), W'(exp_o[0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_flip_flop_shift_reg
